mac_mem_sequencer: RTL and testbench

//  Controller for the 16-sector x 16-entry x 16-bit two-read-port memory (sectors 0-14 RAM, sector 15 ROM).
//  On a command it streams operand pairs to the MAC datapath:
//  - port 1 reads from sector A and port 2 from sector B, at the same address, one pair per cycle;
//  - it then writes the MAC result back to a destination sector/address.
//  It arbitrates the single memory write port between this write-back and a host loader (weights/inputs).

---
 rtl/mac_mem_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mac_mem_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_mem_sequencer.sv
// Sequencer that streams operand pairs from two memory sectors to a MAC datapath,
// writes the MAC result back, and shares the memory write port with a host loader.
module mac_mem_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int SEL_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  cmd_sector_a,
  input  logic [SEL_W-1:0]  cmd_sector_b,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [SEL_W-1:0]  cmd_dst_sector,
  input  logic [ADDR_W-1:0] cmd_dst_addr,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [ADDR_W-1:0] read_add_1,
  output logic [ADDR_W-1:0] read_add_2,
  output logic [SEL_W-1:0]  read_sector_selector_1,
  output logic [SEL_W-1:0]  read_sector_selector_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  output logic              pair_valid,
  output logic [DATA_W-1:0] pair_a,
  output logic [DATA_W-1:0] pair_b,
  output logic              pair_last,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result_data,
  input  logic              host_wr_req,
  input  logic [SEL_W-1:0]  host_wr_sector,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_gnt,
  output logic              en_write,
  output logic [SEL_W-1:0]  sector_write_select,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] data_write
);

  localparam int                  LEN_W      = ADDR_W + 1;
  localparam logic [SEL_W-1:0]    ROM_SECTOR = '1;
  localparam logic [LEN_W-1:0]    MAX_LEN    = LEN_W'(1 << ADDR_W);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WAIT_RES, S_WRITE} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sec_a_q, sec_a_d, sec_b_q, sec_b_d, dst_sec_q, dst_sec_d;
  logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d, rd_addr_q, rd_addr_d;
  logic [SEL_W-1:0]    rd_sel_1_q, rd_sel_1_d, rd_sel_2_q, rd_sel_2_d;
  logic [LEN_W-1:0]    len_q, len_d, k_q, k_d, last_k;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                pair_valid_q, pair_valid_d, pair_last_q, pair_last_d;
  logic                busy_q, busy_d, done_q, done_d, cmd_err_q, cmd_err_d;
  logic                seq_wr, host_ok, cmd_bad;

  assign last_k  = len_q - LEN_W'(1);
  assign seq_wr  = (state_q == S_WRITE);
  assign host_ok = host_wr_req && !seq_wr;
  assign cmd_bad = (cmd_len == '0) || (cmd_len > MAX_LEN) || (cmd_dst_sector == ROM_SECTOR);

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d      = state_q;
    sec_a_d      = sec_a_q;
    sec_b_d      = sec_b_q;
    len_d        = len_q;
    dst_sec_d    = dst_sec_q;
    dst_addr_d   = dst_addr_q;
    k_d          = k_q;
    result_d     = result_q;
    rd_addr_d    = '0;
    rd_sel_1_d   = '0;
    rd_sel_2_d   = '0;
    pair_valid_d = (state_q == S_READ);
    pair_last_d  = (state_q == S_READ) && (k_q == last_k);
    done_d       = 1'b0;
    cmd_err_d    = host_ok && (host_wr_sector == ROM_SECTOR);
    unique case (state_q)
      S_IDLE: if (start) begin
        sec_a_d    = cmd_sector_a;
        sec_b_d    = cmd_sector_b;
        len_d      = cmd_len;
        dst_sec_d  = cmd_dst_sector;
        dst_addr_d = cmd_dst_addr;
        if (cmd_bad) begin
          cmd_err_d = 1'b1;
        end else begin
          state_d    = S_READ;
          k_d        = '0;
          rd_sel_1_d = cmd_sector_a;
          rd_sel_2_d = cmd_sector_b;
        end
      end
      S_READ: begin
        // The read port registers lead k by nothing: the address shown is the one issued this cycle.
        if (k_q == last_k) begin
          state_d = S_DRAIN;
        end else begin
          k_d        = k_q + LEN_W'(1);
          rd_addr_d  = k_d[ADDR_W-1:0];
          rd_sel_1_d = sec_a_q;
          rd_sel_2_d = sec_b_q;
        end
      end
      S_DRAIN: state_d = S_WAIT_RES;
      S_WAIT_RES: if (result_valid) begin
        result_d = result_data;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sec_a_q      <= '0;
      sec_b_q      <= '0;
      len_q        <= '0;
      dst_sec_q    <= '0;
      dst_addr_q   <= '0;
      k_q          <= '0;
      result_q     <= '0;
      rd_addr_q    <= '0;
      rd_sel_1_q   <= '0;
      rd_sel_2_q   <= '0;
      pair_valid_q <= 1'b0;
      pair_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      sec_a_q      <= sec_a_d;
      sec_b_q      <= sec_b_d;
      len_q        <= len_d;
      dst_sec_q    <= dst_sec_d;
      dst_addr_q   <= dst_addr_d;
      k_q          <= k_d;
      result_q     <= result_d;
      rd_addr_q    <= rd_addr_d;
      rd_sel_1_q   <= rd_sel_1_d;
      rd_sel_2_q   <= rd_sel_2_d;
      pair_valid_q <= pair_valid_d;
      pair_last_q  <= pair_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  // Write port: sequencer write-back wins; host path is combinational so the grant is same-cycle.
  always_comb begin
    en_write            = 1'b0;
    sector_write_select = '0;
    write_address       = '0;
    data_write          = '0;
    host_wr_gnt         = host_ok;
    if (seq_wr) begin
      en_write            = 1'b1;
      sector_write_select = dst_sec_q;
      write_address       = dst_addr_q;
      data_write          = result_q;
    end else if (host_ok && (host_wr_sector != ROM_SECTOR)) begin
      en_write            = 1'b1;
      sector_write_select = host_wr_sector;
      write_address       = host_wr_addr;
      data_write          = host_wr_data;
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign cmd_err                = cmd_err_q;
  assign read_add_1             = rd_addr_q;
  assign read_add_2             = rd_addr_q;
  assign read_sector_selector_1 = rd_sel_1_q;
  assign read_sector_selector_2 = rd_sel_2_q;
  assign pair_valid             = pair_valid_q;
  assign pair_last              = pair_last_q;
  assign pair_a                 = pair_valid_q ? read_data_1 : '0;
  assign pair_b                 = pair_valid_q ? read_data_2 : '0;

endmodule

// File: tb/tb_mac_mem_sequencer.sv
// Bench for mac_mem_sequencer: behavioural 16x16x16 memory with ROM sector 15,
// scoreboard queues for operand pairs and memory writes.
module tb_mac_mem_sequencer;

  logic        clock, reset_n, start;
  logic [3:0]  cmd_sector_a, cmd_sector_b, cmd_dst_sector, cmd_dst_addr;
  logic [4:0]  cmd_len;
  logic        busy, done, cmd_err;
  logic [3:0]  read_add_1, read_add_2, read_sector_selector_1, read_sector_selector_2;
  logic [15:0] read_data_1, read_data_2;
  logic        pair_valid, pair_last;
  logic [15:0] pair_a, pair_b;
  logic        result_valid;
  logic [15:0] result_data;
  logic        host_wr_req;
  logic [3:0]  host_wr_sector, host_wr_addr;
  logic [15:0] host_wr_data;
  logic        host_wr_gnt, en_write;
  logic [3:0]  sector_write_select, write_address;
  logic [15:0] data_write;

  typedef struct packed {logic [15:0] a; logic [15:0] b; logic last;} pair_t;
  typedef struct packed {logic [3:0] sector; logic [3:0] addr; logic [15:0] data;} wr_t;

  pair_t pair_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [15:0] mem [16][16];

  mac_mem_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .cmd_sector_a(cmd_sector_a), .cmd_sector_b(cmd_sector_b), .cmd_len(cmd_len),
    .cmd_dst_sector(cmd_dst_sector), .cmd_dst_addr(cmd_dst_addr),
    .busy(busy), .done(done), .cmd_err(cmd_err),
    .read_add_1(read_add_1), .read_add_2(read_add_2),
    .read_sector_selector_1(read_sector_selector_1), .read_sector_selector_2(read_sector_selector_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .pair_valid(pair_valid), .pair_a(pair_a), .pair_b(pair_b), .pair_last(pair_last),
    .result_valid(result_valid), .result_data(result_data),
    .host_wr_req(host_wr_req), .host_wr_sector(host_wr_sector), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_wr_gnt(host_wr_gnt),
    .en_write(en_write), .sector_write_select(sector_write_select),
    .write_address(write_address), .data_write(data_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: registered reads (old data on same-cycle collision), sector 15 never written.
  initial begin
    for (int s = 0; s < 16; s++)
      for (int a = 0; a < 16; a++)
        mem[s][a] = (s == 15) ? (16'hF000 + 16'(a)) : 16'h0000;
    read_data_1 = '0;
    read_data_2 = '0;
  end

  always @(posedge clock) begin
    read_data_1 <= mem[read_sector_selector_1][read_add_1];
    read_data_2 <= mem[read_sector_selector_2][read_add_2];
    if (en_write && sector_write_select != 4'd15)
      mem[sector_write_select][write_address] <= data_write;
  end

  // Write scoreboard: every en_write cycle must match the next expected write.
  always @(negedge clock) begin
    if (en_write) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got sector=%0d addr=%0d data=%h, none expected",
                 sector_write_select, write_address, data_write);
      end else begin
        wr_t exp;
        exp = wr_q.pop_front();
        if ({sector_write_select, write_address, data_write} !== exp) begin
          errors++;
          $display("FAIL wr_data got sector=%0d addr=%0d data=%h, want sector=%0d addr=%0d data=%h",
                   sector_write_select, write_address, data_write, exp.sector, exp.addr, exp.data);
        end
      end
    end
  end

  task automatic do_start(input logic [3:0] a, input logic [3:0] b, input logic [4:0] len,
                          input logic [3:0] ds, input logic [3:0] da);
    @(posedge clock); #1;
    start = 1'b1; cmd_sector_a = a; cmd_sector_b = b; cmd_len = len;
    cmd_dst_sector = ds; cmd_dst_addr = da;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic expect_pairs(input int n);
    int budget = 0;
    @(negedge clock);
    while (!pair_valid && budget < 8) begin budget++; @(negedge clock); end
    checks++;
    if (pair_valid !== 1'b1) begin
      errors++;
      $display("FAIL pair_timeout got pair_valid=%b, want 1 within 8 cycles", pair_valid);
      pair_q.delete();
      return;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_read got %b want 1", busy); end
    for (int i = 0; i < n; i++) begin
      pair_t exp;
      if (i > 0) @(negedge clock);
      exp = pair_q.pop_front();
      checks++;
      if ({pair_valid, pair_a, pair_b, pair_last} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL pair_%0d got v=%b a=%h b=%h last=%b, want v=1 a=%h b=%h last=%b",
                 i, pair_valid, pair_a, pair_b, pair_last, exp.a, exp.b, exp.last);
      end
    end
    @(negedge clock);
    checks++;
    if (pair_valid !== 1'b0) begin errors++; $display("FAIL pair_extra got pair_valid=%b want 0", pair_valid); end
  endtask

  task automatic send_result(input logic [15:0] d, input logic [3:0] ds, input logic [3:0] da);
    @(posedge clock); #1;
    result_valid = 1'b1; result_data = d;
    wr_q.push_back('{sector: ds, addr: da, data: d});
    @(posedge clock); #1;
    result_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    @(negedge clock);
    while (!done && budget < 8) begin budget++; @(negedge clock); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b, want done=1 busy=0", done, busy);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_width got done=%b want 0", done); end
  endtask

  task automatic host_write(input logic [3:0] s, input logic [3:0] a, input logic [15:0] d);
    int budget = 0;
    if (s != 4'd15) wr_q.push_back('{sector: s, addr: a, data: d});
    @(posedge clock); #1;
    host_wr_req = 1'b1; host_wr_sector = s; host_wr_addr = a; host_wr_data = d;
    @(negedge clock);
    while (!host_wr_gnt && budget < 8) begin budget++; @(negedge clock); end
    checks++;
    if (host_wr_gnt !== 1'b1) begin errors++; $display("FAIL host_gnt got %b want 1", host_wr_gnt); end
    if (s == 4'd15) begin
      checks++;
      if (en_write !== 1'b0) begin errors++; $display("FAIL rom_en_write got %b want 0", en_write); end
    end
    @(posedge clock); #1;
    host_wr_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; cmd_sector_a = 0; cmd_sector_b = 0; cmd_len = 0;
    cmd_dst_sector = 0; cmd_dst_addr = 0; result_valid = 0; result_data = 0;
    host_wr_req = 0; host_wr_sector = 0; host_wr_addr = 0; host_wr_data = 0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, cmd_err, pair_valid, pair_last, pair_a, pair_b, en_write, host_wr_gnt,
         read_add_1, read_add_2, read_sector_selector_1, read_sector_selector_2,
         sector_write_select, write_address, data_write} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b pv=%b en_write=%b ra1=%0d rs1=%0d, want all 0",
               busy, done, cmd_err, pair_valid, en_write, read_add_1, read_sector_selector_1);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) host_write(4'd0, 4'(i), 16'(i + 1));
    for (int i = 0; i < 4; i++)  host_write(4'd1, 4'(i), 16'(10 + i));
    for (int i = 0; i < 4; i++) pair_q.push_back('{a: 16'(i + 1), b: 16'(10 + i), last: (i == 3)});
    do_start(4'd0, 4'd1, 5'd4, 4'd2, 4'd5);
    expect_pairs(4);
    send_result(16'h00AA, 4'd2, 4'd5);
    wait_done();
  endtask

  task automatic test_rom_write();
    host_write(4'd15, 4'd3, 16'hDEAD);
    @(negedge clock);
    checks++;
    if (cmd_err !== 1'b1) begin errors++; $display("FAIL rom_cmd_err got %b want 1", cmd_err); end
    @(negedge clock);
    checks++;
    if (cmd_err !== 1'b0) begin errors++; $display("FAIL rom_cmd_err_width got %b want 0", cmd_err); end
  endtask

  task automatic test_full_len_rom();
    for (int i = 0; i < 16; i++)
      pair_q.push_back('{a: 16'(i + 1), b: 16'hF000 + 16'(i), last: (i == 15)});
    do_start(4'd0, 4'd15, 5'd16, 4'd4, 4'd0);
    expect_pairs(16);
    send_result(16'h1616, 4'd4, 4'd0);
    wait_done();
  endtask

  task automatic test_illegal();
    logic [4:0] lens [3] = '{5'd0, 5'd17, 5'd2};
    logic [3:0] dsts [3] = '{4'd2, 4'd2, 4'd15};
    for (int t = 0; t < 3; t++) begin
      do_start(4'd0, 4'd1, lens[t], dsts[t], 4'd1);
      @(negedge clock);
      checks++;
      if (cmd_err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_%0d got cmd_err=%b busy=%b, want cmd_err=1 busy=0", t, cmd_err, busy);
      end
      @(negedge clock);
      checks++;
      if (cmd_err !== 1'b0 || busy !== 1'b0 || pair_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_after_%0d got cmd_err=%b busy=%b pv=%b, want 0 0 0", t, cmd_err, busy, pair_valid);
      end
    end
  endtask

  task automatic test_arbitration();
    for (int i = 0; i < 2; i++) pair_q.push_back('{a: 16'(i + 1), b: 16'(10 + i), last: (i == 1)});
    do_start(4'd0, 4'd1, 5'd2, 4'd2, 4'd6);
    expect_pairs(2);
    @(posedge clock); #1;
    result_valid = 1'b1; result_data = 16'h55AA;
    wr_q.push_back('{sector: 4'd2, addr: 4'd6, data: 16'h55AA});
    @(posedge clock); #1;
    result_valid = 1'b0;
    host_wr_req = 1'b1; host_wr_sector = 4'd7; host_wr_addr = 4'd6; host_wr_data = 16'h7777;
    wr_q.push_back('{sector: 4'd7, addr: 4'd6, data: 16'h7777});
    @(negedge clock);
    checks++;
    if (host_wr_gnt !== 1'b0 || en_write !== 1'b1) begin
      errors++;
      $display("FAIL arb_in_write got gnt=%b en_write=%b, want gnt=0 en_write=1", host_wr_gnt, en_write);
    end
    @(negedge clock);
    checks++;
    if (host_wr_gnt !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL arb_deferred got gnt=%b done=%b, want gnt=1 done=1", host_wr_gnt, done);
    end
    @(posedge clock); #1;
    host_wr_req = 1'b0;
    @(negedge clock);
    checks++;
    if (mem[2][6] !== 16'h55AA || mem[7][6] !== 16'h7777) begin
      errors++;
      $display("FAIL arb_landed got m[2][6]=%h m[7][6]=%h, want 55aa 7777", mem[2][6], mem[7][6]);
    end
  endtask

  task automatic test_reset_mid_read();
    int budget = 0;
    do_start(4'd0, 4'd1, 5'd16, 4'd6, 4'd6);
    @(negedge clock);
    while (read_add_1 !== 4'd7 && budget < 20) begin budget++; @(negedge clock); end
    checks++;
    if (read_add_1 !== 4'd7) begin errors++; $display("FAIL mid_read_timeout got ra1=%0d want 7", read_add_1); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, cmd_err, pair_valid, pair_last, pair_a, pair_b, en_write, host_wr_gnt,
         read_add_1, read_add_2, read_sector_selector_1, read_sector_selector_2,
         sector_write_select, write_address, data_write} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b pv=%b pa=%h ra1=%0d rs2=%0d en_write=%b, want all 0",
               busy, pair_valid, pair_a, read_add_1, read_sector_selector_2, en_write);
    end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || pair_valid !== 1'b0 || en_write !== 1'b0) begin
        errors++;
        $display("FAIL after_abort_%0d got busy=%b pv=%b en_write=%b, want 0 0 0", i, busy, pair_valid, en_write);
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 2; i++) pair_q.push_back('{a: 16'(i + 1), b: 16'(10 + i), last: (i == 1)});
    do_start(4'd0, 4'd1, 5'd2, 4'd3, 4'd7);
    expect_pairs(2);
    do_start(4'd1, 4'd0, 5'd3, 4'd9, 4'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b1 || pair_valid !== 1'b0) begin
        errors++;
        $display("FAIL start_ignored_%0d got busy=%b pv=%b, want busy=1 pv=0", i, busy, pair_valid);
      end
    end
    send_result(16'h1234, 4'd3, 4'd7);
    wait_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rom_write();
    test_full_len_rom();
    test_illegal();
    test_arbitration();
    test_reset_mid_read();
    test_start_ignored();
    repeat (3) @(negedge clock);
    checks++;
    if (wr_q.size() != 0 || pair_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got writes=%0d pairs=%0d, want 0 0", wr_q.size(), pair_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
